// File: rtl/lr_pkg.sv
// Shared definitions for the linear-regression accelerator residual path.
// Latency: n/a (types, constants and helpers only).
// Backpressure: n/a.
//
// Contents: default widths, the residual-unit state enum, saturation bounds
// for the default residual width and an address-width helper.
package lr_pkg;

    // Default configuration of the accelerator datapath.
    localparam int N_DEF    = 150;  // samples per run
    localparam int DW_DEF   = 20;   // signed operand / residual width
    localparam int FRAC_DEF = 10;   // fractional bits, Q(DW-FRAC).FRAC
    localparam int SW_DEF   = 32;   // SAE accumulator width

    // Residual unit sequencer: one sample walks FETCH -> WAIT -> CALC -> OUT.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_CALC  = 3'd3,
        S_OUT   = 3'd4,
        S_DONE  = 3'd5
    } err_state_t;

    // Residual saturation bounds for the default width.
    localparam logic signed [DW_DEF-1:0] ERR_MAX = {1'b0, {(DW_DEF-1){1'b1}}};
    localparam logic signed [DW_DEF-1:0] ERR_MIN = {1'b1, {(DW_DEF-1){1'b0}}};

    // Address width for n samples; never below one bit so N=1 still has a port.
    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lr_residual.sv
// Saturated residual e = y - (b0 + ((b1*x) >>> FRAC)) for one sample.
// Latency: purely combinational, zero cycles.
// Backpressure: none, no state.
//
// Ports:
//   b0, b1 : signed fixed-point coefficients (intercept, slope)
//   x, y   : signed fixed-point sample
//   err    : residual saturated to the signed DW-bit range
module lr_residual
    import lr_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic signed [DW-1:0] b0,
    input  logic signed [DW-1:0] b1,
    input  logic signed [DW-1:0] x,
    input  logic signed [DW-1:0] y,
    output logic signed [DW-1:0] err
);

    // Two guard bits cover the sum and difference of DW-bit quantities.
    localparam logic signed [DW+1:0] SAT_MAX = {3'b000, {(DW-1){1'b1}}};
    localparam logic signed [DW+1:0] SAT_MIN = {3'b111, {(DW-1){1'b0}}};

    logic signed [2*DW-1:0] prod;
    logic signed [DW+1:0]   pred;
    logic signed [DW+1:0]   e;

    always_comb begin
        // Full-precision product; operands sign-extended before multiplying.
        prod = (2*DW)'(b1) * (2*DW)'(x);
        // Arithmetic shift floors toward -inf, so -1 LSB of product stays -1.
        pred = (DW+2)'(b0) + (DW+2)'(prod >>> FRAC);
        e    = (DW+2)'(y) - pred;

        err = e[DW-1:0];
        if (e > SAT_MAX) begin
            err = SAT_MAX[DW-1:0];
        end else if (e < SAT_MIN) begin
            err = SAT_MIN[DW-1:0];
        end
    end

endmodule

// File: rtl/lr_error_unit.sv
// Re-reads N stored samples, streams saturated residuals and sums |err| (SAE).
// Latency: start accepted at T0 -> sample k on err_valid at T0+4+4k; 4 cycles/sample.
// Backpressure: err_valid held with data/idx/sae stable until err_ready; each stall cycle adds one.
//
// Ports:
//   clk, rst            : clock (rising edge), asynchronous active-high reset
//   start, b0, b1       : run request and coefficients, taken only in IDLE
//   mem_addr            : sample address; x_in/y_in return one cycle later
//   x_in, y_in          : sample read data
//   err_valid/err_ready : residual handshake, err_data/err_idx payload
//   sae                 : saturating sum of |err_data| for the run, held after done
//   busy, done          : busy outside IDLE, done pulses once after the last transfer
module lr_error_unit
    import lr_pkg::*;
#(
    parameter int N    = N_DEF,
    parameter int DW   = DW_DEF,
    parameter int FRAC = FRAC_DEF,
    parameter int AW   = addr_width(N),
    parameter int SW   = SW_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic signed [DW-1:0] b0,
    input  logic signed [DW-1:0] b1,
    output logic [AW-1:0]        mem_addr,
    input  logic signed [DW-1:0] x_in,
    input  logic signed [DW-1:0] y_in,
    output logic                 err_valid,
    input  logic                 err_ready,
    output logic signed [DW-1:0] err_data,
    output logic [AW-1:0]        err_idx,
    output logic [SW-1:0]        sae,
    output logic                 busy,
    output logic                 done
);

    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    err_state_t state;
    err_state_t state_nxt;

    // Coefficients frozen for the whole run; sample registered from memory.
    logic signed [DW-1:0] b0_q;
    logic signed [DW-1:0] b1_q;
    logic signed [DW-1:0] x_q;
    logic signed [DW-1:0] y_q;
    logic [AW-1:0]        idx_q;

    logic signed [DW-1:0] res;
    logic signed [DW:0]   res_ext;
    logic [DW:0]          res_abs;
    logic [SW:0]          sae_sum;
    logic [SW-1:0]        sae_nxt;
    logic                 xfer;
    logic                 last;

    lr_residual #(
        .DW   (DW),
        .FRAC (FRAC)
    ) u_residual (
        .b0  (b0_q),
        .b1  (b1_q),
        .x   (x_q),
        .y   (y_q),
        .err (res)
    );

    // |res| needs one extra bit: the most negative residual maps to 2^(DW-1).
    // The extra accumulator bit is the carry that flags saturation.
    always_comb begin
        res_ext = {res[DW-1], res};
        res_abs = (res_ext < 0) ? DW'(0) - res_ext : res_ext;
        sae_sum = {1'b0, sae} + (SW+1)'(res_abs);
        sae_nxt = sae_sum[SW] ? {SW{1'b1}} : sae_sum[SW-1:0];
    end

    assign xfer = (state == S_OUT) && err_ready;
    assign last = (idx_q == LAST_IDX);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_CALC;
            S_CALC:  state_nxt = S_OUT;
            S_OUT:   if (err_ready) state_nxt = last ? S_DONE : S_FETCH;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state only, so err_valid never sees err_ready.
    always_comb begin
        mem_addr  = idx_q;
        err_valid = (state == S_OUT);
        busy      = (state != S_IDLE);
        done      = (state == S_DONE);
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b0_q     <= '0;
            b1_q     <= '0;
            x_q      <= '0;
            y_q      <= '0;
            idx_q    <= '0;
            err_data <= '0;
            err_idx  <= '0;
            sae      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        b0_q  <= b0;
                        b1_q  <= b1;
                        idx_q <= '0;
                        sae   <= '0;
                    end
                end
                S_WAIT: begin
                    x_q <= x_in;
                    y_q <= y_in;
                end
                S_CALC: begin
                    err_data <= res;
                    err_idx  <= idx_q;
                    sae      <= sae_nxt;
                end
                S_OUT: begin
                    // Index parks at the last sample; it never wraps.
                    if (xfer && !last) begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lr_error_unit.sv
module tb_lr_error_unit;
    import lr_pkg::*;

    localparam int N    = 4;
    localparam int DW   = 20;
    localparam int FRAC = 10;
    localparam int AW   = 2;
    localparam int SW   = 21;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start;
    logic signed [DW-1:0] b0;
    logic signed [DW-1:0] b1;
    logic [AW-1:0]        mem_addr;
    logic signed [DW-1:0] x_in;
    logic signed [DW-1:0] y_in;
    logic                 err_valid;
    logic                 err_ready;
    logic signed [DW-1:0] err_data;
    logic [AW-1:0]        err_idx;
    logic [SW-1:0]        sae;
    logic                 busy;
    logic                 done;

    int n_checks = 0;
    int n_pass   = 0;

    logic signed [DW-1:0] x_mem [N];
    logic signed [DW-1:0] y_mem [N];

    // Results captured by do_run.
    logic signed [DW-1:0] res_dat [N];
    logic [AW-1:0]        res_idx [N];
    logic [AW-1:0]        addr_seen [N];
    int                   vld_cyc [N];
    int                   n_out, done_cyc, busy_low_cyc, ndone;
    logic [SW-1:0]        sae_c1, sae_end;

    always #5 clk = ~clk;

    // Synchronous sample memory: data one cycle after the address.
    always @(posedge clk) begin
        x_in <= x_mem[mem_addr];
        y_in <= y_mem[mem_addr];
    end

    lr_error_unit #(
        .N    (N),
        .DW   (DW),
        .FRAC (FRAC),
        .AW   (AW),
        .SW   (SW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .b0        (b0),
        .b1        (b1),
        .mem_addr  (mem_addr),
        .x_in      (x_in),
        .y_in      (y_in),
        .err_valid (err_valid),
        .err_ready (err_ready),
        .err_data  (err_data),
        .err_idx   (err_idx),
        .sae       (sae),
        .busy      (busy),
        .done      (done)
    );

    task automatic load_mem(input int x0, x1, x2, x3, y0, y1, y2, y3);
        x_mem[0] = x0[DW-1:0]; x_mem[1] = x1[DW-1:0]; x_mem[2] = x2[DW-1:0]; x_mem[3] = x3[DW-1:0];
        y_mem[0] = y0[DW-1:0]; y_mem[1] = y1[DW-1:0]; y_mem[2] = y2[DW-1:0]; y_mem[3] = y3[DW-1:0];
    endtask

    // Full run with err_ready high; cycle c=1 is the cycle after the start edge.
    task automatic do_run(input int b0v, input int b1v, input bit mid_start);
        int c;
        int k;
        @(negedge clk);
        b0 = b0v[DW-1:0]; b1 = b1v[DW-1:0]; start = 1'b1; err_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; b0 = 20'sd0; b1 = 20'sd7;
        c = 1; k = 0; done_cyc = -1; busy_low_cyc = -1; ndone = 0;
        for (int j = 0; j < N; j++) begin vld_cyc[j] = -1; addr_seen[j] = '1; end
        while (c <= 40 && busy_low_cyc < 0) begin
            if (c == 1) sae_c1 = sae;
            if ((c - 1) % 4 == 0 && (c - 1) / 4 < N) addr_seen[(c - 1) / 4] = mem_addr;
            if (err_valid && k < N) begin
                res_dat[k] = err_data; res_idx[k] = err_idx; vld_cyc[k] = c; k++;
            end
            if (done) begin ndone++; if (done_cyc < 0) done_cyc = c; end
            if (!busy) busy_low_cyc = c;
            start = mid_start && (c == 6);
            if (mid_start && c == 6) b0 = 20'sd12345;
            @(posedge clk); #1;
            c++;
        end
        start = 1'b0;
        n_out = k;
        sae_end = sae;
    endtask

    task automatic test_reset();
        #1;
        for (int r = 0; r < 2; r++) begin
            n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", busy); else n_pass++;
            n_checks++; if (err_valid !== 1'b0) $display("FAIL reset_err_valid: got %0b expected 0", err_valid); else n_pass++;
            n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %0b expected 0", done); else n_pass++;
            n_checks++; if (mem_addr !== 2'd0) $display("FAIL reset_mem_addr: got %0d expected 0", mem_addr); else n_pass++;
            n_checks++; if (err_data !== 20'sd0) $display("FAIL reset_err_data: got %0d expected 0", err_data); else n_pass++;
            n_checks++; if (err_idx !== 2'd0) $display("FAIL reset_err_idx: got %0d expected 0", err_idx); else n_pass++;
            n_checks++; if (sae !== 21'd0) $display("FAIL reset_sae: got %0d expected 0", sae); else n_pass++;
            if (r == 0) begin
                @(posedge clk); @(negedge clk); rst = 1'b0;
                @(posedge clk); #1;
            end
        end
    endtask

    // b0=1.0, b1=2.0; start pulsed mid-run with another b0 must be ignored.
    task automatic test_nominal_run();
        int exp_d [N];
        exp_d = '{1024, -1024, 1024, 1928};
        load_mem(3072, 0, -1024, 1024, 8192, 0, 0, 5000);
        do_run(1024, 2048, 1'b1);
        n_checks++; if (n_out !== N) $display("FAIL nom_count: got %0d expected %0d", n_out, N); else n_pass++;
        for (int k = 0; k < N; k++) begin
            n_checks++; if (res_dat[k] !== exp_d[k]) $display("FAIL nom_err_data[%0d]: got %0d expected %0d", k, res_dat[k], exp_d[k]); else n_pass++;
            n_checks++; if (res_idx[k] !== AW'(k)) $display("FAIL nom_err_idx[%0d]: got %0d expected %0d", k, res_idx[k], k); else n_pass++;
            n_checks++; if (vld_cyc[k] !== 4 + 4 * k) $display("FAIL nom_valid_cycle[%0d]: got %0d expected %0d", k, vld_cyc[k], 4 + 4 * k); else n_pass++;
            n_checks++; if (addr_seen[k] !== AW'(k)) $display("FAIL nom_mem_addr[%0d]: got %0d expected %0d", k, addr_seen[k], k); else n_pass++;
        end
        n_checks++; if (done_cyc !== 17) $display("FAIL nom_done_cycle: got %0d expected 17", done_cyc); else n_pass++;
        n_checks++; if (ndone !== 1) $display("FAIL nom_done_count: got %0d expected 1", ndone); else n_pass++;
        n_checks++; if (busy_low_cyc !== 18) $display("FAIL nom_busy_low_cycle: got %0d expected 18", busy_low_cyc); else n_pass++;
        n_checks++; if (sae_end !== 21'd5000) $display("FAIL nom_sae: got %0d expected 5000", sae_end); else n_pass++;
    endtask

    // b1 = 1 LSB: the shifted product floors toward -inf.
    task automatic test_neg_trunc();
        int exp_d [N];
        exp_d = '{1, 0, 2, -2};
        load_mem(-1, 1023, -1025, 2048, 0, 0, 0, 0);
        do_run(0, 1, 1'b0);
        for (int k = 0; k < N; k++) begin
            n_checks++; if (res_dat[k] !== exp_d[k]) $display("FAIL trunc_err_data[%0d]: got %0d expected %0d", k, res_dat[k], exp_d[k]); else n_pass++;
        end
        n_checks++; if (sae_end !== 21'd5) $display("FAIL trunc_sae: got %0d expected 5", sae_end); else n_pass++;
    endtask

    task automatic test_saturation();
        int exp_d [N];
        exp_d = '{524287, 524287, 0, 524287};
        load_mem(0, 0, 0, 0, 524287, 0, -524288, 100);
        do_run(-524288, 0, 1'b0);
        for (int k = 0; k < N; k++) begin
            n_checks++; if (res_dat[k] !== exp_d[k]) $display("FAIL sat_pos[%0d]: got %0d expected %0d", k, res_dat[k], exp_d[k]); else n_pass++;
        end
        n_checks++; if (sae_end !== 21'd1572861) $display("FAIL sat_pos_sae: got %0d expected 1572861", sae_end); else n_pass++;
        // Opposite signs: every residual clips to the negative bound and SAE clips at 2^21-1.
        load_mem(0, 0, 0, 0, -524288, -524288, -524288, -524288);
        do_run(524287, 0, 1'b0);
        for (int k = 0; k < N; k++) begin
            n_checks++; if (res_dat[k] !== ERR_MIN) $display("FAIL sat_neg[%0d]: got %0d expected %0d", k, res_dat[k], ERR_MIN); else n_pass++;
        end
        n_checks++; if (sae_end !== 21'd2097151) $display("FAIL sae_saturate: got %0d expected 2097151", sae_end); else n_pass++;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (sae !== 21'd2097151) $display("FAIL sae_hold: got %0d expected 2097151", sae); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %0b expected 0", busy); else n_pass++;
    endtask

    task automatic test_backpressure();
        int c;
        int nd;
        load_mem(3072, 0, -1024, 1024, 8192, 0, 0, 5000);
        @(negedge clk);
        b0 = 20'sd1024; b1 = 20'sd2048; start = 1'b1; err_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        c = 1;
        while (!err_valid && c < 20) begin @(posedge clk); #1; c++; end
        n_checks++; if (c !== 4) $display("FAIL bp_first_valid: got cycle %0d expected 4", c); else n_pass++;
        for (int s = 1; s <= 5; s++) begin
            @(posedge clk); #1;
            n_checks++; if (err_valid !== 1'b1) $display("FAIL bp_valid_held[%0d]: got %0b expected 1", s, err_valid); else n_pass++;
            n_checks++; if (err_data !== 20'sd1024) $display("FAIL bp_data_stable[%0d]: got %0d expected 1024", s, err_data); else n_pass++;
            n_checks++; if (err_idx !== 2'd0) $display("FAIL bp_idx_stable[%0d]: got %0d expected 0", s, err_idx); else n_pass++;
            n_checks++; if (sae !== 21'd1024) $display("FAIL bp_sae_stable[%0d]: got %0d expected 1024", s, sae); else n_pass++;
        end
        err_ready = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (err_valid !== 1'b0) $display("FAIL bp_after_xfer_valid: got %0b expected 0", err_valid); else n_pass++;
        n_checks++; if (mem_addr !== 2'd1) $display("FAIL bp_next_fetch_addr: got %0d expected 1", mem_addr); else n_pass++;
        c = 0; nd = 0;
        while (busy && c < 40) begin
            if (done) nd++;
            @(posedge clk); #1; c++;
        end
        n_checks++; if (nd !== 1) $display("FAIL bp_done_count: got %0d expected 1", nd); else n_pass++;
        n_checks++; if (sae !== 21'd5000) $display("FAIL bp_sae: got %0d expected 5000", sae); else n_pass++;
    endtask

    // Reset in WAIT of sample 2 (cycle 10), then a clean restart.
    task automatic test_reset_midrun();
        int c;
        int nd;
        load_mem(3072, 0, -1024, 1024, 8192, 0, 0, 5000);
        @(negedge clk);
        b0 = 20'sd1024; b1 = 20'sd2048; start = 1'b1; err_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (c = 1; c < 10; c++) begin @(posedge clk); #1; end
        n_checks++; if (mem_addr !== 2'd2) $display("FAIL mid_pre_addr: got %0d expected 2", mem_addr); else n_pass++;
        n_checks++; if (sae !== 21'd2048) $display("FAIL mid_pre_sae: got %0d expected 2048", sae); else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %0b expected 0", busy); else n_pass++;
        n_checks++; if (err_valid !== 1'b0) $display("FAIL mid_rst_valid: got %0b expected 0", err_valid); else n_pass++;
        n_checks++; if (mem_addr !== 2'd0) $display("FAIL mid_rst_addr: got %0d expected 0", mem_addr); else n_pass++;
        n_checks++; if (err_data !== 20'sd0) $display("FAIL mid_rst_data: got %0d expected 0", err_data); else n_pass++;
        n_checks++; if (err_idx !== 2'd0) $display("FAIL mid_rst_idx: got %0d expected 0", err_idx); else n_pass++;
        n_checks++; if (sae !== 21'd0) $display("FAIL mid_rst_sae: got %0d expected 0", sae); else n_pass++;
        nd = 0;
        for (int s = 0; s < 3; s++) begin
            if (done) nd++;
            @(posedge clk); #1;
        end
        @(negedge clk); rst = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (done) nd++;
            @(posedge clk); #1;
        end
        n_checks++; if (nd !== 0) $display("FAIL mid_rst_no_done: got %0d pulses expected 0", nd); else n_pass++;
        do_run(1024, 2048, 1'b0);
        n_checks++; if (sae_c1 !== 21'd0) $display("FAIL restart_sae_clear: got %0d expected 0", sae_c1); else n_pass++;
        n_checks++; if (res_idx[0] !== 2'd0) $display("FAIL restart_idx0: got %0d expected 0", res_idx[0]); else n_pass++;
        n_checks++; if (res_dat[0] !== 20'sd1024) $display("FAIL restart_data0: got %0d expected 1024", res_dat[0]); else n_pass++;
        n_checks++; if (done_cyc !== 17) $display("FAIL restart_done_cycle: got %0d expected 17", done_cyc); else n_pass++;
        n_checks++; if (sae_end !== 21'd5000) $display("FAIL restart_sae: got %0d expected 5000", sae_end); else n_pass++;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; err_ready = 1'b0; b0 = '0; b1 = '0;
        load_mem(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_nominal_run();
        test_neg_trunc();
        test_saturation();
        test_backpressure();
        test_reset_midrun();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
